riscv_fetch: RTL and testbench

RISCV_FETCH -- requirements
Module: riscv_fetch

---
 rtl/riscv_fetch_if.sv | 24 ++
 rtl/riscv_fetch.sv | 113 +++++++++++
 tb/tb_riscv_fetch.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_fetch_if.sv
// Fetch-unit bundle: redirect input, instruction memory port and decode-side queue head.
// master = fetch unit, slave = surrounding core / memory / decode.
interface riscv_fetch_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_misaligned;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_misaligned
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_misaligned
  );
endinterface

// File: rtl/riscv_fetch.sv
// RISC-V instruction fetch: issues word reads to a fixed 1-cycle memory and queues
// {instr, pc, misaligned} entries for decode, with flush/restart on redirect.
module riscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic          clk,
  input  logic          resetn,
  riscv_fetch_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  typedef enum logic {RUN, HALT_MISALIGNED} mode_e;

  mode_e            mode_q, mode_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      inflight_pc_q;

  logic [31:0]      fifo_instr_q [DEPTH];
  logic [31:0]      fifo_pc_q    [DEPTH];
  logic             fifo_mis_q   [DEPTH];

  logic             head_valid;
  logic             pop;
  logic             aligned;
  logic             room;
  logic             issue;
  logic             push_mark;
  logic             push;
  logic [OCC_W-1:0] occ;
  logic [31:0]      push_instr;
  logic [31:0]      push_pc;

  always_comb begin
    head_valid = (count_q != '0);
    pop        = head_valid && bus.out_ready;
    aligned    = (fetch_pc_q[1:0] == 2'b00);
    // Slots committed after this cycle: queued + returning response - leaving head.
    occ        = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    room       = (occ < OCC_W'(DEPTH));
    issue      = resetn && !bus.redirect_valid && (mode_q == RUN) && aligned && room;
    // A misaligned target is only ever loaded by redirect/reset, so nothing is in flight.
    push_mark  = (mode_q == RUN) && !aligned && !inflight_q && room;
    push       = inflight_q || push_mark;
    push_instr = push_mark ? 32'h0 : bus.imem_rdata;
    push_pc    = push_mark ? fetch_pc_q : inflight_pc_q;
  end

  always_comb begin
    mode_d     = mode_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = inflight_q;
    if (bus.redirect_valid) begin
      mode_d     = RUN;
      fetch_pc_d = bus.redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      inflight_d = 1'b0;
    end else begin
      inflight_d = issue;
      if (issue)     fetch_pc_d = fetch_pc_q + 32'd4;
      if (push_mark) mode_d     = HALT_MISALIGNED;
      if (push)      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      if (pop)       rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mode_q     <= RUN;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  // Datapath storage carries no reset; occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (issue) inflight_pc_q <= fetch_pc_q;
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= push_instr;
      fifo_pc_q[wr_ptr_q]    <= push_pc;
      fifo_mis_q[wr_ptr_q]   <= push_mark;
    end
  end

  assign bus.imem_req       = issue;
  assign bus.imem_addr      = fetch_pc_q[13:0];
  assign bus.out_valid      = head_valid;
  assign bus.out_instr      = head_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
  assign bus.out_pc         = head_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0;
  assign bus.out_misaligned = head_valid && fifo_mis_q[rd_ptr_q];
endmodule

// File: tb/tb_riscv_fetch.sv
// Bench for riscv_fetch: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations on the popped instruction stream.
`timescale 1ns/1ps
module tb_riscv_fetch;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mis;
  } ent_t;

  logic clk = 1'b0;
  logic resetn;
  riscv_fetch_if bus();

  riscv_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Memory returns word = address, one cycle after the request.
  always @(posedge clk) bus.imem_rdata <= {18'h0, bus.imem_addr};

  ent_t        mq[$];
  ent_t        seen[$];
  logic [31:0] mpc;
  logic [31:0] minf_pc;
  bit          minf;
  bit          mhalt;
  bit          started;
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] seen_pc(input int i);
    if (i < seen.size()) return seen[i].pc;
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] seen_instr(input int i);
    if (i < seen.size()) return seen[i].instr;
    return 32'hDEAD_BEEF;
  endfunction

  // Model: compare current outputs, then advance to the state after the next edge.
  always @(negedge clk) begin
    ent_t head;
    bit   pop;
    bit   ereq;
    int   occ;
    head = (mq.size() > 0) ? mq[0] : '0;
    if (started) begin
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      chk("out_instr", bus.out_instr, head.instr);
      chk("out_pc", bus.out_pc, head.pc);
      chk("out_misaligned", 32'(bus.out_misaligned), 32'(head.mis));
    end
    pop  = resetn && !bus.redirect_valid && (mq.size() > 0) && bus.out_ready;
    occ  = mq.size() + int'(minf) - int'(pop);
    ereq = resetn && !bus.redirect_valid && !mhalt && (mpc[1:0] == 2'b00) && (occ < DEPTH);
    if (started) begin
      chk("imem_req", 32'(bus.imem_req), 32'(ereq));
      chk("imem_addr", 32'(bus.imem_addr), 32'(mpc[13:0]));
    end
    if (!resetn) begin
      mpc     = RESET_PC;
      mq.delete();
      minf    = 1'b0;
      mhalt   = 1'b0;
      started = 1'b1;
    end else if (started) begin
      if (bus.redirect_valid) begin
        mpc   = bus.redirect_pc;
        mq.delete();
        minf  = 1'b0;
        mhalt = 1'b0;
      end else begin
        if (pop) begin
          seen.push_back(mq[0]);
          void'(mq.pop_front());
        end
        if (minf) begin
          mq.push_back('{instr: {18'h0, minf_pc[13:0]}, pc: minf_pc, mis: 1'b0});
        end else if (!mhalt && mpc[1:0] != 2'b00) begin
          mq.push_back('{instr: 32'h0, pc: mpc, mis: 1'b1});
          mhalt = 1'b1;
        end
        minf = ereq;
        if (ereq) begin
          minf_pc = mpc;
          mpc     = mpc + 32'd4;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    started = 1'b0;
    resetn  = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b1;
    repeat (3) tick();

    // Reset state, then first request at RESET_PC.
    at_neg();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'h0);
    tick();
    resetn = 1'b1;
    at_neg();
    chk("first_req", 32'(bus.imem_req), 32'h1);
    chk("first_addr", 32'(bus.imem_addr), 32'h0);
    chk("first_no_valid", 32'(bus.out_valid), 32'h0);
    tick();
    tick();
    at_neg();
    chk("latency_valid", 32'(bus.out_valid), 32'h1);
    chk("latency_pc", bus.out_pc, 32'h8000_0000);
    tick();
    tick();
    at_neg();
    chk("seq0_pc", seen_pc(0), 32'h8000_0000);
    chk("seq1_pc", seen_pc(1), 32'h8000_0004);
    chk("seq1_instr", seen_instr(1), 32'h0000_0004);
    chk("seq2_pc", seen_pc(2), 32'h8000_0008);

    // Backpressure: queue fills, fetch stalls, head holds.
    redirect(32'h8000_0000);
    bus.out_ready = 1'b0;
    seen.delete();
    tick();
    bus.redirect_valid = 1'b0;
    repeat (12) tick();
    at_neg();
    chk("stall_req", 32'(bus.imem_req), 32'h0);
    chk("stall_valid", 32'(bus.out_valid), 32'h1);
    chk("stall_head", bus.out_pc, 32'h8000_0000);
    tick();
    bus.out_ready = 1'b1;
    repeat (6) tick();
    at_neg();
    chk("release0", seen_pc(0), 32'h8000_0000);
    chk("release1", seen_pc(1), 32'h8000_0004);
    chk("release2", seen_pc(2), 32'h8000_0008);
    chk("release3", seen_pc(3), 32'h8000_000C);

    // Redirect mid-stream with a response in flight.
    redirect(32'h8000_0100);
    at_neg();
    chk("redir_req_low", 32'(bus.imem_req), 32'h0);
    tick();
    bus.redirect_valid = 1'b0;
    at_neg();
    chk("redir_flushed", 32'(bus.out_valid), 32'h0);
    chk("redir_req", 32'(bus.imem_req), 32'h1);
    chk("redir_addr", 32'(bus.imem_addr), 32'h0100);
    tick();
    tick();
    at_neg();
    chk("redir_head_valid", 32'(bus.out_valid), 32'h1);
    chk("redir_head_pc", bus.out_pc, 32'h8000_0100);
    chk("redir_head_instr", bus.out_instr, 32'h0000_0100);

    // Misaligned target: one marker, then fetch halts until the next redirect.
    redirect(32'h8000_0102);
    tick();
    bus.redirect_valid = 1'b0;
    at_neg();
    chk("mis_no_req", 32'(bus.imem_req), 32'h0);
    tick();
    at_neg();
    chk("mis_valid", 32'(bus.out_valid), 32'h1);
    chk("mis_flag", 32'(bus.out_misaligned), 32'h1);
    chk("mis_pc", bus.out_pc, 32'h8000_0102);
    chk("mis_instr", bus.out_instr, 32'h0);
    repeat (5) tick();
    at_neg();
    chk("halt_req", 32'(bus.imem_req), 32'h0);
    chk("halt_empty", 32'(bus.out_valid), 32'h0);
    redirect(32'h8000_0200);
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    at_neg();
    chk("resume_pc", bus.out_pc, 32'h8000_0200);
    chk("resume_mis", 32'(bus.out_misaligned), 32'h0);

    // Back-to-back redirects: only the last one counts.
    redirect(32'h8000_0300);
    redirect(32'h8000_0400);
    tick();
    bus.redirect_valid = 1'b0;
    seen.delete();
    repeat (3) tick();
    at_neg();
    chk("b2b_first", seen_pc(0), 32'h8000_0400);
    chk("b2b_second", seen_pc(1), 32'h8000_0404);

    // Wrap-around of the fetch address.
    redirect(32'hFFFF_FFFC);
    tick();
    bus.redirect_valid = 1'b0;
    seen.delete();
    repeat (5) tick();
    at_neg();
    chk("wrap0_pc", seen_pc(0), 32'hFFFF_FFFC);
    chk("wrap0_instr", seen_instr(0), 32'h0000_3FFC);
    chk("wrap1_pc", seen_pc(1), 32'h0000_0000);
    chk("wrap2_pc", seen_pc(2), 32'h0000_0004);

    // Reset mid-stream, overriding a simultaneous redirect.
    tick();
    resetn = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0500;
    tick();
    bus.redirect_valid = 1'b0;
    at_neg();
    chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_pc", bus.out_pc, 32'h0);
    chk("mid_rst_instr", bus.out_instr, 32'h0);
    chk("mid_rst_mis", 32'(bus.out_misaligned), 32'h0);
    chk("mid_rst_req", 32'(bus.imem_req), 32'h0);
    tick();
    resetn = 1'b1;
    seen.delete();
    repeat (5) tick();
    at_neg();
    chk("restart0", seen_pc(0), 32'h8000_0000);
    chk("restart1", seen_pc(1), 32'h8000_0004);
    chk("restart2", seen_pc(2), 32'h8000_0008);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
